// File: rtl/int_ctrl_pkg.sv
// ============================================================================
// Module      : int_ctrl_pkg
// Description : Shared state encodings, default sizing and the fixed-priority
//               encoder for the interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package int_ctrl_pkg;

    localparam int c_NUM_SRC_DEFAULT = 4;
    localparam int c_HOLDOFF_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTRY   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Lowest set index wins; an all-zero vector returns 0.
    function automatic logic [3:0] prio_enc(input logic [15:0] vec);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/int_ctrl_if.sv
// ============================================================================
// Module      : int_ctrl_if
// Description : Request, mask, completion and service signals between the
//               processor side (master) and the interrupt controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface int_ctrl_if #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
);
    logic [NUM_SRC-1:0] irq_in;
    logic               mask_wr;
    logic [NUM_SRC-1:0] mask_data;
    logic               done;
    logic               int_out;
    logic [ID_W-1:0]    int_id;
    logic               busy;
    logic [NUM_SRC-1:0] pending;

    modport master (
        output irq_in, mask_wr, mask_data, done,
        input  int_out, int_id, busy, pending
    );

    modport slave (
        input  irq_in, mask_wr, mask_data, done,
        output int_out, int_id, busy, pending
    );
endinterface

`default_nettype wire

// File: rtl/irq_edge_sync.sv
// ============================================================================
// Module      : irq_edge_sync
// Description : Per-line rising-edge detector; INT_CTRL_SYNC_EN inserts a
//               2-flop synchroniser ahead of the detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_edge_sync (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic irq,
    output logic      rise
);
    logic w_sample;
    logic r_hist;

`ifdef INT_CTRL_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= irq;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
`else
    assign w_sample = irq;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_hist <= 1'b0;
        else       r_hist <= w_sample;
    end

    assign rise = w_sample & ~r_hist;

endmodule

`default_nettype wire

// File: rtl/int_ctrl.sv
// ============================================================================
// Module      : int_ctrl
// Description : Fixed-priority interrupt controller: edge-latched pending,
//               mask, single-cycle int pulse, holdoff and service wait.
//               Optional input synchroniser: INT_CTRL_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = c_NUM_SRC_DEFAULT,
    parameter int HOLDOFF = c_HOLDOFF_DEFAULT
) (
    input  wire logic clk,
    input  wire logic reset,
    int_ctrl_if.slave bus
);
    localparam int ID_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(HOLDOFF + 1);

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] w_eligible;
    logic [NUM_SRC-1:0] w_grant;
    logic [3:0]         w_enc;
    logic [ID_W-1:0]    w_winner;
    logic [ID_W-1:0]    r_int_id;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_int_out;
    logic               w_fire;
    state_t             r_state;
    state_t             w_state_nxt;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            irq_edge_sync u_edge (
                .clk   (clk),
                .reset (reset),
                .irq   (bus.irq_in[gi]),
                .rise  (w_rise[gi])
            );
        end
    endgenerate

    assign w_eligible = r_pending & r_mask;
    assign w_enc      = prio_enc(16'(w_eligible));
    assign w_winner   = w_enc[ID_W-1:0];
    assign w_grant    = w_fire ? (NUM_SRC'(1) << w_winner) : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fire      = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_eligible) begin
                    w_fire      = 1'b1;
                    w_cnt_nxt   = CNT_W'(HOLDOFF);
                    w_state_nxt = ENTRY;
                end
            end
            ENTRY: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) w_state_nxt = SERVICE;
            end
            SERVICE: begin
                if (bus.done) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_int_out <= 1'b0;
            r_int_id  <= '0;
            r_pending <= '0;
            r_mask    <= '1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_int_out <= w_fire;
            if (w_fire) r_int_id <= w_winner;
            // A fresh edge on the line being granted keeps it pending.
            r_pending <= (r_pending & ~w_grant) | w_rise;
            if (bus.mask_wr) r_mask <= bus.mask_data;
        end
    end

    assign bus.int_out = r_int_out;
    assign bus.int_id  = r_int_id;
    assign bus.busy    = (r_state != IDLE);
    assign bus.pending = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_int_ctrl.sv
// ============================================================================
// Module      : tb_int_ctrl
// Description : Directed self-checking bench for int_ctrl (either build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_ctrl;
    import int_ctrl_pkg::*;

`ifdef INT_CTRL_SYNC_EN
    localparam int E = 2;
`else
    localparam int E = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    int_ctrl_if #(.NUM_SRC(4), .ID_W(2)) bus ();

    int_ctrl #(.NUM_SRC(4), .HOLDOFF(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic done_pulse();
        bus.done = 1'b1;
        step(1);
        bus.done = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.irq_in    = 4'b0000;
        bus.mask_wr   = 1'b0;
        bus.mask_data = 4'b0000;
        bus.done      = 1'b0;
        step(2);
        chk("rst_int_out", 32'(bus.int_out), 32'd0);
        chk("rst_busy",    32'(bus.busy),    32'd0);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        chk("rst_int_id",  32'(bus.int_id),  32'd0);
        chk("rst_mask",    32'(u_dut.r_mask), 32'hF);
        reset = 1'b0;
        step(1);

        // Single request held high
        bus.irq_in = 4'b0100;
        step(1 + E);
        chk("s_pend",    32'(bus.pending), 32'h4);
        chk("s_nopulse", 32'(bus.int_out), 32'd0);
        step(1);
        chk("s_pulse",   32'(bus.int_out), 32'd1);
        chk("s_id",      32'(bus.int_id),  32'd2);
        chk("s_clr",     32'(bus.pending), 32'd0);
        chk("s_busy",    32'(bus.busy),    32'd1);
        step(1);
        chk("s_width",   32'(bus.int_out), 32'd0);
        step(2);
        chk("s_entry3",  32'(u_dut.r_state), 32'(ENTRY));
        step(1);
        chk("s_service", 32'(u_dut.r_state), 32'(SERVICE));
        step(3);
        chk("s_hold_out",  32'(bus.int_out), 32'd0);
        chk("s_hold_busy", 32'(bus.busy),    32'd1);
        chk("s_level",     32'(bus.pending), 32'd0);
        done_pulse();
        chk("s_idle",    32'(bus.busy),   32'd0);
        chk("s_id_held", 32'(bus.int_id), 32'd2);
        step(2);
        chk("s_no_second", 32'(bus.int_out), 32'd0);
        bus.irq_in = 4'b0000;
        step(1 + E);

        // Priority: bits 3 and 1 together
        bus.irq_in = 4'b1010;
        step(1 + E);
        chk("p_pend",   32'(bus.pending), 32'hA);
        step(1);
        chk("p_pulse1", 32'(bus.int_out), 32'd1);
        chk("p_id1",    32'(bus.int_id),  32'd1);
        chk("p_left",   32'(bus.pending), 32'h8);
        step(4);
        chk("p_service", 32'(u_dut.r_state), 32'(SERVICE));
        done_pulse();
        chk("p_gap_busy", 32'(bus.busy),    32'd0);
        chk("p_gap_out",  32'(bus.int_out), 32'd0);
        step(1);
        chk("p_pulse2", 32'(bus.int_out), 32'd1);
        chk("p_id2",    32'(bus.int_id),  32'd3);
        chk("p_empty",  32'(bus.pending), 32'd0);
        step(4);
        done_pulse();
        bus.irq_in = 4'b0000;
        step(1 + E);

        // Masking
        bus.mask_wr   = 1'b1;
        bus.mask_data = 4'b1110;
        step(1);
        bus.mask_wr = 1'b0;
        chk("m_mask", 32'(u_dut.r_mask), 32'hE);
        bus.irq_in = 4'b0001;
        step(1 + E);
        chk("m_pend", 32'(bus.pending), 32'h1);
        step(3);
        chk("m_nopulse", 32'(bus.int_out), 32'd0);
        chk("m_idle",    32'(bus.busy),    32'd0);
        chk("m_kept",    32'(bus.pending), 32'h1);
        bus.mask_wr   = 1'b1;
        bus.mask_data = 4'b1111;
        step(1);
        bus.mask_wr = 1'b0;
        chk("m_wr_edge", 32'(bus.int_out), 32'd0);
        step(1);
        chk("m_pulse", 32'(bus.int_out), 32'd1);
        chk("m_id",    32'(bus.int_id),  32'd0);
        step(4);
        done_pulse();
        bus.irq_in = 4'b0000;
        step(1 + E);

        // Re-edge during service, done outside SERVICE ignored
        bus.irq_in = 4'b0100;
        step(1 + E);
        step(1);
        chk("c_id", 32'(bus.int_id), 32'd2);
        done_pulse();
        chk("c_done_ign", 32'(u_dut.r_state), 32'(ENTRY));
        step(3);
        chk("c_service", 32'(u_dut.r_state), 32'(SERVICE));
        bus.irq_in = 4'b0000;
        step(1 + E);
        bus.irq_in = 4'b0100;
        step(1 + E);
        chk("c_pend",  32'(bus.pending), 32'h4);
        chk("c_quiet", 32'(bus.int_out), 32'd0);
        done_pulse();
        chk("c_idle", 32'(bus.busy), 32'd0);
        step(1);
        chk("c_pulse", 32'(bus.int_out), 32'd1);
        chk("c_id2",   32'(bus.int_id),  32'd2);
        chk("c_clr",   32'(bus.pending), 32'd0);
        step(4);
        done_pulse();
        done_pulse();
        chk("c_idle_done_busy", 32'(bus.busy),    32'd0);
        chk("c_idle_done_out",  32'(bus.int_out), 32'd0);
        chk("c_idle_done_id",   32'(bus.int_id),  32'd2);
        bus.irq_in = 4'b0000;
        step(1 + E);

        // Set-wins: new edge on bit 2 exactly on its grant edge
        bus.irq_in = 4'b1000;
        step(1 + E);
        step(1);
        chk("w_id3", 32'(bus.int_id), 32'd3);
        bus.irq_in = 4'b1100;
        step(1 + E);
        chk("w_absorb", 32'(bus.pending), 32'h4);
        bus.irq_in = 4'b1000;
        step(1 + E);
        step(4);
`ifdef INT_CTRL_SYNC_EN
        bus.irq_in = 4'b1100;
        step(1);
        done_pulse();
        step(1);
`else
        done_pulse();
        bus.irq_in = 4'b1100;
        step(1);
`endif
        chk("w_pulse", 32'(bus.int_out), 32'd1);
        chk("w_id2",   32'(bus.int_id),  32'd2);
        chk("w_setwin", 32'(bus.pending), 32'h4);
        step(4);
        done_pulse();
        step(1);
        chk("w_refire", 32'(bus.int_out), 32'd1);
        chk("w_refire_id", 32'(bus.int_id), 32'd2);
        chk("w_refire_clr", 32'(bus.pending), 32'd0);
        step(4);

        // Asynchronous reset in SERVICE with a pending bit and custom mask
        bus.mask_wr   = 1'b1;
        bus.mask_data = 4'b0101;
        step(1);
        bus.mask_wr = 1'b0;
        bus.irq_in  = 4'b1110;
        step(1 + E);
        chk("r_pre_pend", 32'(bus.pending), 32'h2);
        chk("r_pre_busy", 32'(bus.busy),    32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("r_int_out", 32'(bus.int_out), 32'd0);
        chk("r_busy",    32'(bus.busy),    32'd0);
        chk("r_pending", 32'(bus.pending), 32'd0);
        chk("r_mask",    32'(u_dut.r_mask), 32'hF);
        chk("r_int_id",  32'(bus.int_id),  32'd0);
        step(1);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
